// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM mode controller.
//   mode_t        : active PWM unit (MODE_NONE .. MOOD)
//   state_t       : sequencer state
//   SW_AUTO       : switch code that selects auto-cycle
//   unit_rst_for  : per-unit reset vector with only the given unit released
//   next_mode     : auto-cycle successor (LINEAR -> SINE -> SERVO -> MOOD -> LINEAR)
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_NONE = 3'd0,
    LINEAR    = 3'd1,
    SINE      = 3'd2,
    SERVO     = 3'd3,
    MOOD      = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PARK  = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [3:0] SW_AUTO = 4'h8;

  // bit0 linear, bit1 sine, bit2 servo, bit3 mood; 1 = held in reset
  function automatic logic [3:0] unit_rst_for(mode_t m);
    logic [3:0] r;
    r = 4'hF;
    unique case (m)
      LINEAR:  r = 4'hE;
      SINE:    r = 4'hD;
      SERVO:   r = 4'hB;
      MOOD:    r = 4'h7;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  function automatic mode_t next_mode(mode_t m);
    mode_t n;
    n = LINEAR;
    unique case (m)
      LINEAR:  n = SINE;
      SINE:    n = SERVO;
      SERVO:   n = MOOD;
      default: n = LINEAR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pwm_mode_ctrl_if.sv
// Bundle between the switch inputs, the controller and the PWM units / output mux.
//   sw           : raw mode switches (into the controller)
//   mode_sel     : active mode, 0 none .. 4 mood
//   unit_rst     : per-unit reset, 1 = held in reset
//   pos_override : servo position forced to park_pos
//   park_pos     : servo park position, 2**(RES-1)
//   busy         : transition (park or blank) in progress
interface pwm_mode_ctrl_if #(
  parameter int unsigned RES = 8
);
  logic [3:0]     sw;
  logic [2:0]     mode_sel;
  logic [3:0]     unit_rst;
  logic           pos_override;
  logic [RES-1:0] park_pos;
  logic           busy;

  // Controller side
  modport master (
    input  sw,
    output mode_sel,
    output unit_rst,
    output pos_override,
    output park_pos,
    output busy
  );

  // Switch / PWM-unit side
  modport slave (
    output sw,
    input  mode_sel,
    input  unit_rst,
    input  pos_override,
    input  park_pos,
    input  busy
  );
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer. The raw input is registered once; a value is accepted after
// CYCLES further consecutive equal samples of that register. accept_o pulses for
// one cycle only when the accepted value differs from the previous one.
//   clk, rst  : clock, asynchronous active-high reset
//   sw_i      : raw switch vector
//   value_o   : last accepted value
//   accept_o  : one-cycle pulse on a newly accepted value
module sw_debounce #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CYCLES = 1_250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] value_o,
  output logic             accept_o
);

  localparam int unsigned     CntW    = $clog2(CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);
  // Counter parks here after acceptance so a stable input is accepted only once
  localparam logic [CntW-1:0] CntDone = CntW'(CYCLES);

  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] value_q;
  logic [CntW-1:0]  cnt_q;
  logic             accept_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q     <= '0;
      value_q  <= '0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      sw_q     <= sw_i;
      accept_q <= 1'b0;
      if (sw_i != sw_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CntDone) begin
        cnt_q <= cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          value_q  <= sw_q;
          accept_q <= (sw_q != value_q);
        end
      end
    end
  end

  assign value_o  = value_q;
  assign accept_o = accept_q;

endmodule

// File: rtl/pwm_mode_ctrl.sv
// Sequencer for the four PWM units (linear fade, sine fade, servo, mood RGB).
// Debounces the mode switches, decodes the request and walks every mode change
// through a safe sequence: park the servo (when leaving servo), blank all units,
// then enable the new unit. Switch code 8 rotates through all units.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : switch input and unit-control outputs (see pwm_mode_ctrl_if)
module pwm_mode_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned RES             = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
  parameter int unsigned PARK_CYCLES     = 12_500_000,
  parameter int unsigned BLANK_CYCLES    = 2_500_000,
  parameter int unsigned DWELL_CYCLES    = 625_000_000
) (
  input  logic            clk,
  input  logic            rst,
  pwm_mode_ctrl_if.master bus_io
);

  localparam int unsigned ParkW  = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [ParkW-1:0]  ParkLast  = ParkW'(PARK_CYCLES - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [RES-1:0]    ParkPos   = {1'b1, {(RES-1){1'b0}}};

  logic [3:0] deb_value;
  logic       deb_accept;

  sw_debounce #(
    .WIDTH  (4),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (bus_io.sw),
    .value_o  (deb_value),
    .accept_o (deb_accept)
  );

  state_t             state_q;
  mode_t              cur_q;
  mode_t              target_q;
  mode_t              mode_sel_q;
  logic               auto_q;
  logic [3:0]         unit_rst_q;
  logic               pos_override_q;
  logic               busy_q;
  logic [ParkW-1:0]   park_cnt_q;
  logic [BlankW-1:0]  blank_cnt_q;
  logic [DwellW-1:0]  dwell_cnt_q;

  mode_t req_target;
  logic  req_auto;
  mode_t eff_target;
  logic  dwell_done;
  logic  run_exit;

  // Request decode of the debounced value
  always_comb begin
    req_target = MODE_NONE;
    req_auto   = 1'b0;
    if (deb_value == SW_AUTO) begin
      req_target = LINEAR;
      req_auto   = 1'b1;
    end else if (deb_value >= 4'd1 && deb_value <= 4'd4) begin
      req_target = mode_t'(deb_value[2:0]);
    end
  end

  always_comb begin
    // A same-cycle accept overrides the stored target
    eff_target = deb_accept ? req_target : target_q;
    // An explicit accept takes priority over the auto-cycle timeout
    dwell_done = auto_q && !deb_accept && (dwell_cnt_q == DwellLast);
    run_exit   = (state_q == RUN) &&
                 ((deb_accept && (req_target != cur_q)) || dwell_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_q          <= MODE_NONE;
      target_q       <= MODE_NONE;
      mode_sel_q     <= MODE_NONE;
      auto_q         <= 1'b0;
      unit_rst_q     <= 4'hF;
      pos_override_q <= 1'b0;
      busy_q         <= 1'b0;
      park_cnt_q     <= '0;
      blank_cnt_q    <= '0;
      dwell_cnt_q    <= '0;
    end else begin
      if (deb_accept) begin
        target_q <= req_target;
        auto_q   <= req_auto;
      end

      unique case (state_q)
        IDLE: begin
          if (deb_accept && (req_target != MODE_NONE)) begin
            state_q        <= BLANK;
            mode_sel_q     <= MODE_NONE;
            unit_rst_q     <= 4'hF;
            pos_override_q <= 1'b0;
            busy_q         <= 1'b1;
            blank_cnt_q    <= '0;
          end
        end

        RUN: begin
          if (run_exit) begin
            busy_q <= 1'b1;
            if (cur_q == SERVO) begin
              // Servo holds the park position before it is released
              state_q        <= PARK;
              mode_sel_q     <= SERVO;
              unit_rst_q     <= unit_rst_for(SERVO);
              pos_override_q <= 1'b1;
              park_cnt_q     <= '0;
            end else begin
              state_q        <= BLANK;
              mode_sel_q     <= MODE_NONE;
              unit_rst_q     <= 4'hF;
              pos_override_q <= 1'b0;
              blank_cnt_q    <= '0;
            end
          end
          if (dwell_done) begin
            target_q <= next_mode(cur_q);
          end
          if (deb_accept || !auto_q) begin
            dwell_cnt_q <= '0;
          end else if (!dwell_done) begin
            dwell_cnt_q <= dwell_cnt_q + DwellW'(1);
          end
        end

        PARK: begin
          if (park_cnt_q == ParkLast) begin
            state_q        <= BLANK;
            mode_sel_q     <= MODE_NONE;
            unit_rst_q     <= 4'hF;
            pos_override_q <= 1'b0;
            busy_q         <= 1'b1;
            blank_cnt_q    <= '0;
          end else begin
            park_cnt_q <= park_cnt_q + ParkW'(1);
          end
        end

        BLANK: begin
          if (blank_cnt_q == BlankLast) begin
            busy_q         <= 1'b0;
            pos_override_q <= 1'b0;
            if (eff_target == MODE_NONE) begin
              state_q    <= IDLE;
              mode_sel_q <= MODE_NONE;
              unit_rst_q <= 4'hF;
            end else begin
              state_q     <= RUN;
              cur_q       <= eff_target;
              mode_sel_q  <= eff_target;
              unit_rst_q  <= unit_rst_for(eff_target);
              dwell_cnt_q <= '0;
            end
          end else begin
            blank_cnt_q <= blank_cnt_q + BlankW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.mode_sel     = mode_sel_q;
  assign bus_io.unit_rst     = unit_rst_q;
  assign bus_io.pos_override = pos_override_q;
  assign bus_io.park_pos     = ParkPos;
  assign bus_io.busy         = busy_q;

endmodule

// File: tb/tb_pwm_mode_ctrl.sv
// Bench for pwm_mode_ctrl: directed scenarios followed by random switch activity,
// every cycle compared against a behavioural model built on run lengths and
// countdown timers.
module tb_pwm_mode_ctrl;

  localparam int unsigned RES = 8;
  localparam int DB = 4;
  localparam int PK = 6;
  localparam int BL = 8;
  localparam int DW = 20;

  localparam int PhIdle  = 0;
  localparam int PhRun   = 1;
  localparam int PhPark  = 2;
  localparam int PhBlank = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_mode_ctrl_if #(.RES(RES)) bus ();

  pwm_mode_ctrl #(
    .RES             (RES),
    .DEBOUNCE_CYCLES (DB),
    .PARK_CYCLES     (PK),
    .BLANK_CYCLES    (BL),
    .DWELL_CYCLES    (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_last;    // most recent raw switch sample
  int m_runlen;  // how many consecutive edges it has been seen
  int m_acc;     // last accepted switch value
  bit m_pulse;   // new-value accept visible this cycle
  int m_phase;
  int m_cur;
  int m_tgt;
  bit m_auto;
  int m_rem;     // cycles left in park/blank
  int m_dwell;   // cycles spent auto-running in the current mode

  int sw_drv;

  function automatic void model_reset();
    m_last   = 0;
    m_runlen = 1;  // the reset value of the sample register counts as one sample
    m_acc    = 0;
    m_pulse  = 0;
    m_phase  = PhIdle;
    m_cur    = 0;
    m_tgt    = 0;
    m_auto   = 0;
    m_rem    = 0;
    m_dwell  = 0;
  endfunction

  function automatic void leave_mode();
    if (m_cur == 3) begin
      m_phase = PhPark;
      m_rem   = PK;
    end else begin
      m_phase = PhBlank;
      m_rem   = BL;
    end
  endfunction

  function automatic void model_step(input int s);
    bit pulse_in;
    int acc_in;
    pulse_in = m_pulse;
    acc_in   = m_acc;

    // A value is taken once it has been sampled DB+1 edges in a row
    if (s == m_last) m_runlen++;
    else begin
      m_last   = s;
      m_runlen = 1;
    end
    m_pulse = 0;
    if (m_runlen == DB + 1) begin
      m_pulse = (m_last != m_acc);
      m_acc   = m_last;
    end

    if (pulse_in) begin
      if (acc_in == 8) begin
        m_tgt  = 1;
        m_auto = 1;
      end else if (acc_in >= 1 && acc_in <= 4) begin
        m_tgt  = acc_in;
        m_auto = 0;
      end else begin
        m_tgt  = 0;
        m_auto = 0;
      end
    end

    case (m_phase)
      PhIdle: begin
        if (pulse_in && m_tgt != 0) begin
          m_phase = PhBlank;
          m_rem   = BL;
        end
      end
      PhRun: begin
        if (pulse_in) begin
          m_dwell = 0;
          if (m_tgt != m_cur) leave_mode();
        end else if (m_auto) begin
          m_dwell++;
          if (m_dwell == DW) begin
            m_tgt = (m_cur % 4) + 1;
            leave_mode();
          end
        end else begin
          m_dwell = 0;
        end
      end
      PhPark: begin
        m_rem--;
        if (m_rem == 0) begin
          m_phase = PhBlank;
          m_rem   = BL;
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_tgt == 0) m_phase = PhIdle;
          else begin
            m_phase = PhRun;
            m_cur   = m_tgt;
            m_dwell = 0;
          end
        end
      end
    endcase
  endfunction

  task automatic check_outputs();
    int e_mode;
    int e_urst;
    int e_po;
    int e_busy;
    e_mode = 0;
    e_urst = 15;
    e_po   = 0;
    e_busy = 0;
    case (m_phase)
      PhRun: begin
        e_mode = m_cur;
        e_urst = 15 & ~(1 << (m_cur - 1));
      end
      PhPark: begin
        e_mode = 3;
        e_urst = 15 & ~(1 << 2);
        e_po   = 1;
        e_busy = 1;
      end
      PhBlank: e_busy = 1;
      default: ;
    endcase
    check_eq("mode_sel", 32'(bus.mode_sel), e_mode);
    check_eq("unit_rst", 32'(bus.unit_rst), e_urst);
    check_eq("pos_override", 32'(bus.pos_override), e_po);
    check_eq("busy", 32'(bus.busy), e_busy);
    check_eq("park_pos", 32'(bus.park_pos), 1 << (RES - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step(sw_drv);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input int v, input int n);
    sw_drv = v;
    bus.sw = 4'(v);
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pick;
    int v;
    rst    = 1'b1;
    sw_drv = 0;
    bus.sw = 4'h0;
    model_reset();
    #1;
    check_outputs();
    check_eq("rst_unit_rst", 32'(bus.unit_rst), 32'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: first mode from reset
    hold(1, 20);
    check_eq("t1_mode", 32'(bus.mode_sel), 1);
    check_eq("t1_unit_rst", 32'(bus.unit_rst), 32'hE);

    // 2: short glitch is ignored
    hold(2, 2);
    hold(1, 15);
    check_eq("t2_mode", 32'(bus.mode_sel), 1);
    check_eq("t2_busy", 32'(bus.busy), 0);

    // 3: leaving servo parks first
    hold(3, 25);
    check_eq("t3_mode_servo", 32'(bus.mode_sel), 3);
    hold(4, 8);
    check_eq("t3_park_override", 32'(bus.pos_override), 1);
    check_eq("t3_park_pos", 32'(bus.park_pos), 128);
    check_eq("t3_park_unit_rst", 32'(bus.unit_rst), 32'hB);
    hold(4, 22);
    check_eq("t3_mode", 32'(bus.mode_sel), 4);
    check_eq("t3_unit_rst", 32'(bus.unit_rst), 32'h7);

    // 4: retarget during blank
    hold(2, 7);
    check_eq("t4_in_blank", 32'(bus.busy), 1);
    hold(1, 20);
    check_eq("t4_mode", 32'(bus.mode_sel), 1);

    // 5: auto-cycle through all units
    hold(8, 150);

    // 6: asynchronous reset in the middle of park
    hold(3, 40);
    check_eq("t6_mode_servo", 32'(bus.mode_sel), 3);
    hold(0, 8);
    check_eq("t6_parking", 32'(bus.pos_override), 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_rst_mode", 32'(bus.mode_sel), 0);
    check_eq("t6_rst_override", 32'(bus.pos_override), 0);
    check_eq("t6_rst_unit_rst", 32'(bus.unit_rst), 32'hF);
    check_eq("t6_rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(0, 30);
    check_eq("t6_idle_mode", 32'(bus.mode_sel), 0);
    check_eq("t6_idle_busy", 32'(bus.busy), 0);

    // Random switch activity, including glitches and undefined codes
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: v = 0;
        5: v = 8;
        6: v = int'($urandom_range(0, 15));
        default: v = pick;
      endcase
      hold(v, int'($urandom_range(1, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
